periph_bus_arbiter: RTL and testbench

//   Two-master arbiter for the shared data-side bus (data memory, timer, UART, instr-mem port 2).

---
 rtl/periph_bus_arbiter_if.sv | 18 +
 rtl/periph_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_periph_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_arbiter_if.sv
// rtl/periph_bus_arbiter_if.sv - one initiator channel into the shared data-side bus arbiter
interface periph_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    we;
  logic                    lock;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, we, lock, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/periph_bus_arbiter.sv
// rtl/periph_bus_arbiter.sv - two-master arbiter sequencing IDLE/ACCESS/RESP accesses onto one registered slave strobe set
module periph_bus_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter bit M0_PRIORITY = 1'b0,
  parameter int MAX_LOCK    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  periph_bus_arbiter_if.slave     m0,
  periph_bus_arbiter_if.slave     m1,
  output logic                    s_wr_en,
  output logic                    s_rd_en,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_be,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  output logic                    bus_owner,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

  state_t                  state, state_nxt;
  logic [3:0]              lock_cnt;
  logic                    lock_held;
  logic                    owner_req;
  logic                    win_valid;
  logic                    win_sel;
  logic                    locked_win;
  logic                    win_we;
  logic                    win_lock;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic [DATA_WIDTH/8-1:0] win_be;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    win_valid  = 1'b0;
    win_sel    = bus_owner;
    locked_win = 1'b0;
    owner_req  = bus_owner ? m1.req : m0.req;
    case (state)
      ACCESS: state_nxt = RESP;
      IDLE, RESP: begin
        // Lock only extends an ongoing burst, so it is honoured in RESP but not from IDLE.
        if (state == RESP && lock_held && owner_req && lock_cnt < LOCK_MAX) begin
          win_valid  = 1'b1;
          win_sel    = bus_owner;
          locked_win = 1'b1;
        end else if (m0.req && m1.req) begin
          win_valid = 1'b1;
          win_sel   = M0_PRIORITY ? 1'b0 : ~bus_owner;
        end else if (m0.req) begin
          win_valid = 1'b1;
          win_sel   = 1'b0;
        end else if (m1.req) begin
          win_valid = 1'b1;
          win_sel   = 1'b1;
        end
        state_nxt = win_valid ? ACCESS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    win_we    = win_sel ? m1.we    : m0.we;
    win_lock  = win_sel ? m1.lock  : m0.lock;
    win_addr  = win_sel ? m1.addr  : m0.addr;
    win_wdata = win_sel ? m1.wdata : m0.wdata;
    win_be    = win_sel ? m1.be    : m0.be;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0.gnt    <= 1'b0;
      m1.gnt    <= 1'b0;
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      m0.rdata  <= '0;
      m1.rdata  <= '0;
      s_wr_en   <= 1'b0;
      s_rd_en   <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_be      <= '0;
      bus_owner <= 1'b1;
      lock_held <= 1'b0;
      lock_cnt  <= 4'd0;
    end else begin
      m0.gnt    <= 1'b0;
      m1.gnt    <= 1'b0;
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      s_wr_en   <= 1'b0;
      s_rd_en   <= 1'b0;
      if (win_valid) begin
        bus_owner <= win_sel;
        lock_held <= win_lock;
        lock_cnt  <= locked_win ? lock_cnt + 4'd1 : 4'd0;
        s_wr_en   <= win_we;
        s_rd_en   <= ~win_we;
        s_addr    <= win_addr;
        s_wdata   <= win_wdata;
        s_be      <= win_be;
        if (win_sel) m1.gnt <= 1'b1;
        else         m0.gnt <= 1'b1;
      end else if (state == IDLE) begin
        lock_cnt <= 4'd0;
      end
      // Read data is captured while the strobe is still up, then presented with rvalid in RESP.
      if (state == ACCESS && s_rd_en) begin
        if (bus_owner) begin
          m1.rdata  <= s_rdata;
          m1.rvalid <= 1'b1;
        end else begin
          m0.rdata  <= s_rdata;
          m0.rvalid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == ACCESS) || (state == RESP);

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb/tb_periph_bus_arbiter.sv - directed vector bench for periph_bus_arbiter
module tb_periph_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  periph_bus_arbiter_if a0 ();
  periph_bus_arbiter_if a1 ();
  periph_bus_arbiter_if p0 ();
  periph_bus_arbiter_if p1 ();

  logic        a_wr_en, a_rd_en, a_owner, a_busy;
  logic [31:0] a_addr, a_wdata, a_srd;
  logic [3:0]  a_be;
  logic        p_wr_en, p_rd_en, p_owner, p_busy;
  logic [31:0] p_addr, p_wdata, p_srd;
  logic [3:0]  p_be;

  periph_bus_arbiter #(.M0_PRIORITY(1'b0), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst), .m0(a0), .m1(a1),
    .s_wr_en(a_wr_en), .s_rd_en(a_rd_en), .s_addr(a_addr), .s_wdata(a_wdata),
    .s_be(a_be), .s_rdata(a_srd), .bus_owner(a_owner), .busy(a_busy)
  );

  periph_bus_arbiter #(.M0_PRIORITY(1'b1), .MAX_LOCK(4)) dut_p (
    .clk(clk), .rst(rst), .m0(p0), .m1(p1),
    .s_wr_en(p_wr_en), .s_rd_en(p_rd_en), .s_addr(p_addr), .s_wdata(p_wdata),
    .s_be(p_be), .s_rdata(p_srd), .bus_owner(p_owner), .busy(p_busy)
  );

  int checks = 0;
  int failures = 0;
  int strobe_viol = 0;
  logic a_prev = 1'b0;
  logic p_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if ((a_wr_en | a_rd_en) && a_prev) strobe_viol++;
      if ((p_wr_en | p_rd_en) && p_prev) strobe_viol++;
      if (a_wr_en && a_rd_en) strobe_viol++;
      if (p_wr_en && p_rd_en) strobe_viol++;
    end
    a_prev = a_wr_en | a_rd_en;
    p_prev = p_wr_en | p_rd_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic m, input logic req, input logic we,
                       input logic lock, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    if (!p && !m) begin a0.req = req; a0.we = we; a0.lock = lock; a0.addr = addr; a0.wdata = wdata; a0.be = be; end
    if (!p &&  m) begin a1.req = req; a1.we = we; a1.lock = lock; a1.addr = addr; a1.wdata = wdata; a1.be = be; end
    if ( p && !m) begin p0.req = req; p0.we = we; p0.lock = lock; p0.addr = addr; p0.wdata = wdata; p0.be = be; end
    if ( p &&  m) begin p1.req = req; p1.we = we; p1.lock = lock; p1.addr = addr; p1.wdata = wdata; p1.be = be; end
  endtask

  task automatic idle_all();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic gnt_of(input logic m);
    return m ? a1.gnt : a0.gnt;
  endfunction

  function automatic logic rvalid_of(input logic m);
    return m ? a1.rvalid : a0.rvalid;
  endfunction

  function automatic logic [31:0] rdata_of(input logic m);
    return m ? a1.rdata : a0.rdata;
  endfunction

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] srd;
    logic        exp_wr;
    logic        exp_rd;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0200_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'h3, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_5A5A, 4'hC, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 4'h1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000};

    idle_all();
    a_srd = 32'h0;
    p_srd = 32'h5555_AAAA;
    rst = 1'b1;
    tick();
    chk("rst_gnt0", {31'b0, a0.gnt}, 32'd0);
    chk("rst_rvalid0", {31'b0, a0.rvalid}, 32'd0);
    chk("rst_rd_en", {31'b0, a_rd_en}, 32'd0);
    chk("rst_wr_en", {31'b0, a_wr_en}, 32'd0);
    chk("rst_addr", a_addr, 32'd0);
    chk("rst_rdata0", a0.rdata, 32'd0);
    chk("rst_owner", {31'b0, a_owner}, 32'd1);
    chk("rst_busy", {31'b0, a_busy}, 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, vecs[i].m, 1'b1, vecs[i].we, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      a_srd = vecs[i].srd;
      tick();
      chk($sformatf("vec%0d_wr_en", i), {31'b0, a_wr_en}, {31'b0, vecs[i].exp_wr});
      chk($sformatf("vec%0d_rd_en", i), {31'b0, a_rd_en}, {31'b0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_gnt", i), {31'b0, gnt_of(vecs[i].m)}, 32'd1);
      chk($sformatf("vec%0d_other_gnt", i), {31'b0, gnt_of(~vecs[i].m)}, 32'd0);
      chk($sformatf("vec%0d_addr", i), a_addr, vecs[i].addr);
      chk($sformatf("vec%0d_wdata", i), a_wdata, vecs[i].wdata);
      chk($sformatf("vec%0d_be", i), {28'b0, a_be}, {28'b0, vecs[i].be});
      chk($sformatf("vec%0d_owner", i), {31'b0, a_owner}, {31'b0, vecs[i].m});
      drive(1'b0, vecs[i].m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      chk($sformatf("vec%0d_rvalid", i), {31'b0, rvalid_of(vecs[i].m)}, {31'b0, vecs[i].exp_rvalid});
      chk($sformatf("vec%0d_rdata", i), rdata_of(vecs[i].m), vecs[i].exp_rdata);
      chk($sformatf("vec%0d_resp_strobe", i), {30'b0, a_wr_en, a_rd_en}, 32'd0);
      chk($sformatf("vec%0d_resp_busy", i), {31'b0, a_busy}, 32'd1);
      tick();
      chk($sformatf("vec%0d_idle_busy", i), {31'b0, a_busy}, 32'd0);
      chk($sformatf("vec%0d_idle_rvalid", i), {31'b0, rvalid_of(vecs[i].m)}, 32'd0);
    end

    // Round-robin tie straight after reset: master 0 first, then master 1.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h11, 4'hF);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h22, 4'hF);
    tick();
    chk("rr_first_gnt0", {31'b0, a0.gnt}, 32'd1);
    chk("rr_first_gnt1", {31'b0, a1.gnt}, 32'd0);
    chk("rr_first_addr", a_addr, 32'h10);
    chk("rr_first_owner", {31'b0, a_owner}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("rr_resp_rvalid0", {31'b0, a0.rvalid}, 32'd0);
    tick();
    chk("rr_second_gnt1", {31'b0, a1.gnt}, 32'd1);
    chk("rr_second_wr_en", {31'b0, a_wr_en}, 32'd1);
    chk("rr_second_wdata", a_wdata, 32'h22);
    chk("rr_second_owner", {31'b0, a_owner}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    chk("rr_idle_busy", {31'b0, a_busy}, 32'd0);

    // Fixed priority: master 1 waits until master 0 releases req.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("prio_m0_gnt%0d", k), {31'b0, p0.gnt}, 32'd1);
      chk($sformatf("prio_m1_wait%0d", k), {31'b0, p1.gnt}, 32'd0);
      if (k == 3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      chk($sformatf("prio_rvalid%0d", k), {31'b0, p0.rvalid}, 32'd1);
    end
    tick();
    chk("prio_m1_gnt", {31'b0, p1.gnt}, 32'd1);
    chk("prio_m1_addr", p_addr, 32'h80);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("prio_m1_rdata", p1.rdata, 32'h5555_AAAA);
    tick();

    // Lock: master 1 keeps the bus for 1 + MAX_LOCK accesses, then master 0 gets in.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC0, 32'h77, 4'hF);
    tick();
    chk("lock_gnt1_0", {31'b0, a1.gnt}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hD0, 32'h66, 4'hF);
    for (int k = 1; k < 5; k++) begin
      tick();
      tick();
      chk($sformatf("lock_gnt1_%0d", k), {31'b0, a1.gnt}, 32'd1);
      chk($sformatf("lock_m0_wait%0d", k), {31'b0, a0.gnt}, 32'd0);
    end
    tick();
    tick();
    chk("lock_release_gnt0", {31'b0, a0.gnt}, 32'd1);
    chk("lock_release_gnt1", {31'b0, a1.gnt}, 32'd0);
    chk("lock_release_owner", {31'b0, a_owner}, 32'd0);
    chk("lock_release_addr", a_addr, 32'hD0);
    idle_all();
    tick();
    tick();
    chk("lock_idle_busy", {31'b0, a_busy}, 32'd0);

    // Reset in the middle of an access.
    a_srd = 32'h0BAD_F00D;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0200_0020, 32'h0, 4'hF);
    tick();
    chk("mid_rd_en_before", {31'b0, a_rd_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rd_en_async", {31'b0, a_rd_en}, 32'd0);
    chk("mid_gnt_async", {31'b0, a0.gnt}, 32'd0);
    chk("mid_owner_async", {31'b0, a_owner}, 32'd1);
    chk("mid_busy_async", {31'b0, a_busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rvalid_held_low", {31'b0, a0.rvalid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_gnt0", {31'b0, a0.gnt}, 32'd1);
    chk("post_rst_rd_en", {31'b0, a_rd_en}, 32'd1);
    chk("post_rst_addr", a_addr, 32'h0200_0020);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("post_rst_rvalid", {31'b0, a0.rvalid}, 32'd1);
    chk("post_rst_rdata", a0.rdata, 32'h0BAD_F00D);
    tick();

    chk("strobe_rules", strobe_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
